axi_read_arbiter: RTL and testbench
===================================

// Module: axi_read_arbiter
// PURPOSE
// - Shares one downstream AXI read port (AR+R) between NUM_M upstream masters (IM/DM wrappers).
// - Round-robin grant per transaction.
// - Grant is locked from AR issue until the RLAST handshake.
// - R beats are routed back to the granted master only.
// - A watchdog terminates hung bursts with SLVERR so no master stalls forever.
// PARAMETERS
// - NUM_M    2    number of upstream masters (2..4)
// - TIMEOUT  255  max idle cycles in DATA with no R handshake before abort (8-bit counter)
// PORTS
// - clk          in   1                 clock
// - rst          in   1                 reset, asynchronous, active-low
// - m_arvalid    in   NUM_M             per-master AR valid
// - m_arready    out  NUM_M             per-master AR ready
// - m_arid       in   NUM_M*ID_BITS     per-master ARID (slice i = master i)
// - m_araddr     in   NUM_M*ADDR_BITS   per-master ARADDR
// - m_arlen      in   NUM_M*LEN_BITS    per-master ARLEN
// - m_arsize     in   NUM_M*SIZE_BITS   per-master ARSIZE
// - m_arburst    in   NUM_M*2           per-master ARBURST
// - m_rvalid     out  NUM_M             per-master R valid
// - m_rready     in   NUM_M             per-master R ready
// - m_rdata      out  DATA_BITS         R data, broadcast; qualify with m_rvalid
// - m_rid        out  ID_BITS           R id, broadcast
// - m_rresp      out  2                 R resp, broadcast
// - m_rlast      out  1                 R last, broadcast
// - s_ar{id,addr,len,size,burst}  out  as above (single)   downstream AR payload
// - s_arvalid / s_arready         out / in   1             downstream AR handshake
// - s_r{id,data,resp,last,valid}  in         as above      downstream R
// - s_rready                      out        1             downstream R ready
// - busy         out  1                 FSM not in IDLE
// - grant        out  $clog2(NUM_M)     index of locked master; valid when busy
// BEHAVIOUR
// - Reset values: state IDLE; outputs all 0; rr_ptr = 0, so master 0 has highest priority first.
// - IDLE:
//   - Pick the first requester at or after rr_ptr, modulo NUM_M.
//   - Register its payload and grant index; go to ADDR next cycle.
//   - No AR output in IDLE, so arbitration costs 1 cycle of latency.
// - ADDR:
//   - s_arvalid = 1 with the registered payload; payload is stable until handshake.
//   - m_arready[grant] = s_arready combinationally; all other m_arready = 0.
//   - On s_arvalid && s_arready: go to DATA and set rr_ptr = grant + 1 (wrap to 0 at NUM_M).
// - DATA:
//   - m_rvalid[grant] = s_rvalid; s_rready = m_rready[grant]; R payload passes through combinationally.
//   - All other m_rvalid = 0; every m_arready = 0.
//   - Each R handshake clears the watchdog.
//   - R handshake with s_rlast = 1: go to IDLE.
//   - The RRESP value does not matter; retry on error is the master's job.
// - Watchdog:
//   - Counts in DATA while there is no R handshake.
//   - When the count reaches TIMEOUT: go to ABORT.
// - ABORT:
//   - Drive m_rvalid[grant] = 1, rresp = SLVERR (2'b10), rlast = 1, rdata = 0, rid = granted ARID.
//   - s_rready = 1, which drains and drops any late beat.
//   - Once m_rready[grant] = 1: go to IDLE.
// - Boundary conditions:
//   - Simultaneous requests: rr_ptr decides; a requester is never starved beyond NUM_M-1 transactions.
//   - A request that drops m_arvalid before its grant is simply skipped; one sampled in IDLE is committed.
//   - ARLEN = 0 (single beat): DATA lasts exactly until the first RLAST handshake.
//   - s_rvalid while in IDLE or ADDR is ignored (s_rready = 0).
//   - Reset mid-transaction returns to IDLE immediately and rr_ptr returns to 0.
// STRUCTURE
// - Shared package axi_arb_pkg holds:
//   - state enum (IDLE, ADDR, DATA, ABORT);
//   - RESP_SLVERR constant;
//   - function rr_pick(req, ptr) -> index.
// - Width macros come from the existing AXI define header.
// - Sub-module rr_arbiter (NUM_M, req, ptr -> gnt_idx, gnt_valid) is the only natural split.
//   - It is combinational and is reused later by the write-side arbiter.
// TESTING
// - Single read:
//   - Stimulus: M0 ARADDR=0x0000_0010, ARLEN=0; slave RDATA=0xDEADBEEF, RLAST=1.
//   - Response: s_arvalid in the cycle after m_arvalid; M0 sees the data once; busy returns to 0.
// - Contention:
//   - Stimulus: M0 and M1 request in the same cycle from reset.
//   - Response: M0 is served first, then M1, and rr_ptr = 0 after both.
// - Fairness:
//   - Stimulus: M0 requests continuously while M1 requests once.
//   - Response: M1 is granted after at most one M0 transaction.
// - Burst with backpressure:
//   - Stimulus: ARLEN = 3, and m_rready toggles every cycle.
//   - Response: 4 beats in order, s_rready mirrors m_rready, RLAST only on the 4th beat.
// - Timeout:
//   - Stimulus: after AR, the slave never asserts RVALID.
//   - Response: at cycle TIMEOUT (255) M0 gets RRESP = 2'b10, RLAST = 1; the FSM returns to IDLE.
// - Reset in DATA:
//   - Stimulus: assert rst low mid-burst.
//   - Response: all outputs are 0 asynchronously; after release, a fresh M1 request is granted normally.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared types, AXI widths and round-robin helper for the read arbiter
//
// Contents:
//   ID_BITS/ADDR_BITS/LEN_BITS/SIZE_BITS/DATA_BITS  AXI field widths
//   RESP_SLVERR                                     response code used on watchdog abort
//   arb_state_e                                     arbiter FSM states
//   rr_pick(req, ptr, n)                            first requester at or after ptr, modulo n
package axi_arb_pkg;

  localparam int ID_BITS   = 4;
  localparam int ADDR_BITS = 32;
  localparam int LEN_BITS  = 8;
  localparam int SIZE_BITS = 3;
  localparam int DATA_BITS = 32;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    ABORT = 2'd3
  } arb_state_e;

  // Supports up to 4 requesters. With no request set, ptr is returned and the
  // caller is expected to qualify the result with |req.
  function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] ptr,
                                         input int         n);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = 2'((int'(ptr) + k) % n);
      if (k < n && !found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/axi_read_arbiter_rr.sv
// rtl/axi_read_arbiter_rr.sv - combinational round-robin picker shared by the AXI arbiters
//
// Ports:
//   req_i        in   NUM_M   request vector
//   ptr_i        in   IDX_W   index with highest priority this round
//   gnt_idx_o    out  IDX_W   selected requester
//   gnt_valid_o  out  1       at least one request present
module rr_arbiter #(
  parameter  int NUM_M = 2,
  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);
  import axi_arb_pkg::*;

  logic [3:0] req_ext;
  logic [1:0] ptr_ext;
  logic [1:0] pick;

  always_comb begin
    req_ext               = '0;
    req_ext[NUM_M-1:0]    = req_i;
    ptr_ext               = '0;
    ptr_ext[IDX_W-1:0]    = ptr_i;
    pick                  = rr_pick(req_ext, ptr_ext, NUM_M);
  end

  assign gnt_idx_o   = pick[IDX_W-1:0];
  assign gnt_valid_o = |req_i;

endmodule

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - shares one downstream AXI read port between NUM_M masters
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   m_ar{valid,id,addr,len,size,burst}  in   packed per-master AR channel (slice i = master i)
//   m_arready                   out  per-master AR ready
//   m_rvalid / m_rready         out/in  per-master R handshake
//   m_r{data,id,resp,last}      out  R payload broadcast to all masters, qualify with m_rvalid
//   s_ar{valid,id,addr,len,size,burst} / s_arready  downstream AR channel
//   s_r{valid,data,id,resp,last} / s_rready         downstream R channel
//   busy                        out  a transaction is in progress
//   grant                       out  index of the locked master, meaningful while busy
module axi_read_arbiter #(
  parameter  int NUM_M   = 2,
  parameter  int TIMEOUT = 255,
  localparam int IDX_W   = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_M-1:0]                        m_arvalid,
  output logic [NUM_M-1:0]                        m_arready,
  input  logic [NUM_M*axi_arb_pkg::ID_BITS-1:0]   m_arid,
  input  logic [NUM_M*axi_arb_pkg::ADDR_BITS-1:0] m_araddr,
  input  logic [NUM_M*axi_arb_pkg::LEN_BITS-1:0]  m_arlen,
  input  logic [NUM_M*axi_arb_pkg::SIZE_BITS-1:0] m_arsize,
  input  logic [NUM_M*2-1:0]                      m_arburst,
  output logic [NUM_M-1:0]                        m_rvalid,
  input  logic [NUM_M-1:0]                        m_rready,
  output logic [axi_arb_pkg::DATA_BITS-1:0]       m_rdata,
  output logic [axi_arb_pkg::ID_BITS-1:0]         m_rid,
  output logic [1:0]                              m_rresp,
  output logic                                    m_rlast,
  output logic [axi_arb_pkg::ID_BITS-1:0]         s_arid,
  output logic [axi_arb_pkg::ADDR_BITS-1:0]       s_araddr,
  output logic [axi_arb_pkg::LEN_BITS-1:0]        s_arlen,
  output logic [axi_arb_pkg::SIZE_BITS-1:0]       s_arsize,
  output logic [1:0]                              s_arburst,
  output logic                                    s_arvalid,
  input  logic                                    s_arready,
  input  logic [axi_arb_pkg::ID_BITS-1:0]         s_rid,
  input  logic [axi_arb_pkg::DATA_BITS-1:0]       s_rdata,
  input  logic [1:0]                              s_rresp,
  input  logic                                    s_rlast,
  input  logic                                    s_rvalid,
  output logic                                    s_rready,
  output logic                                    busy,
  output logic [IDX_W-1:0]                        grant
);
  import axi_arb_pkg::*;

  // The watchdog fires on the TIMEOUT-th consecutive DATA cycle without a beat.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  arb_state_e             state_q;
  logic [IDX_W-1:0]       grant_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [7:0]             wd_cnt_q;
  logic [ID_BITS-1:0]     ar_id_q;
  logic [ADDR_BITS-1:0]   ar_addr_q;
  logic [LEN_BITS-1:0]    ar_len_q;
  logic [SIZE_BITS-1:0]   ar_size_q;
  logic [1:0]             ar_burst_q;

  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   r_hs;

  rr_arbiter #(.NUM_M(NUM_M)) u_rr (
    .req_i      (m_arvalid),
    .ptr_i      (rr_ptr_q),
    .gnt_idx_o  (pick_idx),
    .gnt_valid_o(pick_valid)
  );

  assign r_hs = s_rvalid && s_rready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      wd_cnt_q   <= '0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // The payload is captured here so a master that later drops its
          // request cannot change what goes downstream.
          if (pick_valid) begin
            grant_q    <= pick_idx;
            ar_id_q    <= m_arid[int'(pick_idx)*ID_BITS +: ID_BITS];
            ar_addr_q  <= m_araddr[int'(pick_idx)*ADDR_BITS +: ADDR_BITS];
            ar_len_q   <= m_arlen[int'(pick_idx)*LEN_BITS +: LEN_BITS];
            ar_size_q  <= m_arsize[int'(pick_idx)*SIZE_BITS +: SIZE_BITS];
            ar_burst_q <= m_arburst[int'(pick_idx)*2 +: 2];
            wd_cnt_q   <= '0;
            state_q    <= ADDR;
          end
        end
        ADDR: begin
          if (s_arready) begin
            state_q  <= DATA;
            rr_ptr_q <= (grant_q == IDX_W'(NUM_M - 1)) ? '0 : grant_q + 1'b1;
          end
        end
        DATA: begin
          if (r_hs) begin
            wd_cnt_q <= '0;
            if (s_rlast) state_q <= IDLE;
          end else if (wd_cnt_q == WD_LAST) begin
            wd_cnt_q <= '0;
            state_q  <= ABORT;
          end else begin
            wd_cnt_q <= wd_cnt_q + 8'd1;
          end
        end
        ABORT: begin
          if (m_rready[grant_q]) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    s_rready  = 1'b0;
    s_arvalid = 1'b0;
    s_arid    = '0;
    s_araddr  = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_arburst = '0;
    m_rdata   = '0;
    m_rid     = '0;
    m_rresp   = '0;
    m_rlast   = 1'b0;
    case (state_q)
      ADDR: begin
        s_arvalid          = 1'b1;
        s_arid             = ar_id_q;
        s_araddr           = ar_addr_q;
        s_arlen            = ar_len_q;
        s_arsize           = ar_size_q;
        s_arburst          = ar_burst_q;
        m_arready[grant_q] = s_arready;
      end
      DATA: begin
        m_rvalid[grant_q] = s_rvalid;
        s_rready          = m_rready[grant_q];
        m_rdata           = s_rdata;
        m_rid             = s_rid;
        m_rresp           = s_rresp;
        m_rlast           = s_rlast;
      end
      ABORT: begin
        // Synthesised error terminator; any late downstream beat is accepted
        // and discarded so the slave cannot wedge the port.
        m_rvalid[grant_q] = 1'b1;
        s_rready          = 1'b1;
        m_rid             = ar_id_q;
        m_rresp           = RESP_SLVERR;
        m_rlast           = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign grant = grant_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - self-checking bench for axi_read_arbiter
module tb_axi_read_arbiter;
  import axi_arb_pkg::*;

  localparam int N  = 2;
  localparam int TO = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]            m_arvalid, m_arready, m_rvalid, m_rready;
  logic [N*ID_BITS-1:0]    m_arid;
  logic [N*ADDR_BITS-1:0]  m_araddr;
  logic [N*LEN_BITS-1:0]   m_arlen;
  logic [N*SIZE_BITS-1:0]  m_arsize;
  logic [N*2-1:0]          m_arburst;
  logic [DATA_BITS-1:0]    m_rdata, s_rdata;
  logic [ID_BITS-1:0]      m_rid, s_arid, s_rid;
  logic [1:0]              m_rresp, s_rresp, s_arburst;
  logic                    m_rlast, s_rlast, s_arvalid, s_arready, s_rvalid, s_rready, busy;
  logic [ADDR_BITS-1:0]    s_araddr;
  logic [LEN_BITS-1:0]     s_arlen;
  logic [SIZE_BITS-1:0]    s_arsize;
  logic [0:0]              grant;

  logic [ID_BITS-1:0]      p_id    [N];
  logic [ADDR_BITS-1:0]    p_addr  [N];
  logic [LEN_BITS-1:0]     p_len   [N];
  logic [SIZE_BITS-1:0]    p_size  [N];
  logic [1:0]              p_burst [N];
  bit                      persist [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      m_arid[i*ID_BITS +: ID_BITS]       = p_id[i];
      m_araddr[i*ADDR_BITS +: ADDR_BITS] = p_addr[i];
      m_arlen[i*LEN_BITS +: LEN_BITS]    = p_len[i];
      m_arsize[i*SIZE_BITS +: SIZE_BITS] = p_size[i];
      m_arburst[i*2 +: 2]                = p_burst[i];
    end
  end

  axi_read_arbiter #(.NUM_M(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rid(m_rid),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .busy(busy), .grant(grant)
  );

  int passed = 0;
  int total  = 0;
  int model_ptr = 0;

  // Observations gathered by serve_txn for the scenario tasks to judge.
  bit                   ar_ok;
  int                   ar_lat, obs_g, route_bad, mirror_bad;
  logic [ADDR_BITS-1:0] obs_addr;
  logic [LEN_BITS-1:0]  obs_len;
  logic [ID_BITS-1:0]   obs_id;
  logic [N-1:0]         arready_vec;
  logic                 addr_rready, busy_after;
  logic [DATA_BITS-1:0] rx_data[$];
  logic [DATA_BITS-1:0] tx_data[$];
  logic                 rx_last[$];

  // Reference rule: first requester at or after the priority pointer, wrapping.
  function automatic int exp_pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic rand_payload(input int m);
    p_id[m]    = ID_BITS'($urandom);
    p_addr[m]  = $urandom;
    p_len[m]   = LEN_BITS'($urandom_range(0, 3));
    p_size[m]  = 3'd2;
    p_burst[m] = 2'b01;
  endtask

  // Acts as the downstream slave for one transaction and records what the
  // masters see. Called mid-cycle while the arbiter is in IDLE.
  task automatic serve_txn(input int len, input bit bp, input logic [DATA_BITS-1:0] first_data);
    logic [DATA_BITS-1:0] d;
    logic [N-1:0]         expv;
    int                   beat;
    bit                   tog;
    ar_ok = 1'b0; ar_lat = 0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (s_arvalid) begin ar_ok = 1'b1; break; end
      @(posedge clk); #1;
      ar_lat++;
    end
    if (!ar_ok) return;
    obs_g = int'(grant); obs_addr = s_araddr; obs_len = s_arlen; obs_id = s_arid;
    s_rvalid = 1'b1; #1;
    addr_rready = s_rready;
    s_rvalid = 1'b0;
    s_arready = 1'b1; #1;
    arready_vec = m_arready;
    @(posedge clk); #1;
    s_arready = 1'b0;
    if (!persist[obs_g]) m_arvalid[obs_g] = 1'b0;
    rx_data.delete(); tx_data.delete(); rx_last.delete();
    route_bad = 0; mirror_bad = 0; beat = 0; tog = 1'b0;
    expv = '0; expv[obs_g] = 1'b1;
    for (int c = 0; c < 64 && beat <= len; c++) begin
      d = (beat == 0) ? first_data : $urandom;
      s_rvalid = 1'b1; s_rdata = d; s_rid = obs_id; s_rresp = 2'b00;
      s_rlast  = (beat == len);
      m_rready = N'($urandom);
      m_rready[obs_g] = bp ? tog : 1'b1;
      tog = ~tog;
      #1;
      if (m_rvalid !== expv) route_bad++;
      if (s_rready !== m_rready[obs_g]) mirror_bad++;
      if (s_rready) begin
        rx_data.push_back(m_rdata); rx_last.push_back(m_rlast); tx_data.push_back(d);
        beat++;
      end
      @(posedge clk); #1;
    end
    s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '0;
    #1;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b0; m_arvalid = '0; m_rready = '0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = '1; s_rid = '1; s_rresp = 2'b11;
    repeat (3) @(posedge clk);
    #2;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passed++;
    total++; if (s_arvalid !== 1'b0 || s_araddr !== '0 || s_arlen !== '0)
      $display("FAIL reset_ar: arvalid %0b addr %0h len %0h want 0", s_arvalid, s_araddr, s_arlen); else passed++;
    total++; if (m_rvalid !== '0 || s_rready !== 1'b0 || m_arready !== '0)
      $display("FAIL reset_hs: rvalid %0b rready %0b arready %0b want 0", m_rvalid, s_rready, m_arready); else passed++;
    total++; if (m_rdata !== '0 || m_rlast !== 1'b0 || m_rresp !== 2'b00 || grant !== '0)
      $display("FAIL reset_rpay: data %0h last %0b resp %0b grant %0d want 0", m_rdata, m_rlast, m_rresp, grant); else passed++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #2;
    total++; if (s_rready !== 1'b0 || m_rvalid !== '0)
      $display("FAIL idle_ignores_r: s_rready %0b m_rvalid %0b want 0", s_rready, m_rvalid); else passed++;
    s_rvalid = 1'b0; s_rlast = 1'b0; model_ptr = 0;
  endtask

  task automatic test_single_read();
    rand_payload(0); p_addr[0] = 32'h0000_0010; p_len[0] = '0; persist[0] = 1'b0;
    m_arvalid = 2'b01;
    serve_txn(0, 1'b0, 32'hDEADBEEF);
    total++; if (!ar_ok || ar_lat !== 1) $display("FAIL single_ar_latency: seen %0b after %0d cycles want 1", ar_ok, ar_lat); else passed++;
    total++; if (obs_g !== 0 || obs_addr !== 32'h10) $display("FAIL single_ar: grant %0d addr %0h want 0 10", obs_g, obs_addr); else passed++;
    total++; if (arready_vec !== 2'b01 || addr_rready !== 1'b0)
      $display("FAIL single_addr_phase: arready %0b rready %0b want 01 0", arready_vec, addr_rready); else passed++;
    total++; if (rx_data.size() != 1 || rx_data[0] !== 32'hDEADBEEF || rx_last[0] !== 1'b1)
      $display("FAIL single_data: beats %0d data %0h want 1 deadbeef", rx_data.size(), (rx_data.size() > 0) ? rx_data[0] : 32'h0); else passed++;
    total++; if (busy_after !== 1'b0 || route_bad != 0) $display("FAIL single_end: busy %0b route_bad %0d want 0 0", busy_after, route_bad); else passed++;
    model_ptr = 1;
  endtask

  task automatic test_contention();
    int exp_m;
    rst = 1'b0; repeat (2) @(posedge clk); #1; rst = 1'b1; model_ptr = 0;
    @(posedge clk); #1;
    for (int rnd = 0; rnd < 4; rnd++) begin
      if (rnd == 0 || rnd == 2) begin
        rand_payload(0); rand_payload(1); persist[0] = 1'b0; persist[1] = 1'b0;
        m_arvalid = 2'b11;
      end
      exp_m = exp_pick(m_arvalid, model_ptr);
      serve_txn(int'(p_len[exp_m]), 1'b0, $urandom);
      total++; if (!ar_ok || obs_g !== exp_m || obs_addr !== p_addr[exp_m])
        $display("FAIL contention_round%0d: grant %0d addr %0h want %0d %0h", rnd, obs_g, obs_addr, exp_m, p_addr[exp_m]); else passed++;
      model_ptr = (exp_m + 1) % N;
    end
  endtask

  task automatic test_fairness();
    int exp_m, n0;
    bit got1;
    rand_payload(0); rand_payload(1); persist[0] = 1'b1; persist[1] = 1'b0;
    m_arvalid = 2'b11; n0 = 0; got1 = 1'b0;
    for (int t = 0; t < 3 && !got1; t++) begin
      exp_m = exp_pick(m_arvalid, model_ptr);
      serve_txn(int'(p_len[exp_m]), 1'b0, $urandom);
      total++; if (!ar_ok || obs_g !== exp_m) $display("FAIL fair_grant%0d: grant %0d want %0d", t, obs_g, exp_m); else passed++;
      model_ptr = (exp_m + 1) % N;
      if (obs_g == 1) got1 = 1'b1; else n0++;
    end
    m_arvalid[0] = 1'b0; persist[0] = 1'b0;
    total++; if (!got1 || n0 > 1) $display("FAIL fair_wait: m1 served %0b after %0d m0 txns want 1 <=1", got1, n0); else passed++;
  endtask

  task automatic test_burst_backpressure();
    int bad;
    logic [3:0] lastv;
    m_arvalid = '0; rand_payload(0); p_len[0] = 8'd3; persist[0] = 1'b0; m_arvalid[0] = 1'b1;
    serve_txn(3, 1'b1, $urandom);
    total++; if (!ar_ok || obs_len !== 8'd3) $display("FAIL burst_ar: seen %0b len %0d want 1 3", ar_ok, obs_len); else passed++;
    bad = 0; lastv = '0;
    for (int i = 0; i < rx_data.size(); i++) begin
      if (rx_data[i] !== tx_data[i]) bad++;
      if (i < 4) lastv[i] = rx_last[i];
    end
    total++; if (rx_data.size() != 4 || bad != 0) $display("FAIL burst_data: beats %0d bad %0d want 4 0", rx_data.size(), bad); else passed++;
    total++; if (lastv !== 4'b1000) $display("FAIL burst_rlast: got %b want 1000", lastv); else passed++;
    total++; if (mirror_bad != 0 || route_bad != 0) $display("FAIL burst_mirror: mirror_bad %0d route_bad %0d want 0 0", mirror_bad, route_bad); else passed++;
    model_ptr = (obs_g + 1) % N;
  endtask

  task automatic test_random();
    int exp_m, k, bad;
    bit bp;
    m_arvalid = '0;
    for (int rnd = 0; rnd < 12; rnd++) begin
      for (int i = 0; i < N; i++)
        if (!m_arvalid[i] && $urandom_range(0, 1) == 1) begin
          rand_payload(i); persist[i] = 1'b0; m_arvalid[i] = 1'b1;
        end
      if (m_arvalid == '0) begin
        k = $urandom_range(0, N - 1); rand_payload(k); persist[k] = 1'b0; m_arvalid[k] = 1'b1;
      end
      exp_m = exp_pick(m_arvalid, model_ptr);
      bp = 1'($urandom_range(0, 1));
      serve_txn(int'(p_len[exp_m]), bp, $urandom);
      total++; if (!ar_ok || obs_g !== exp_m || obs_addr !== p_addr[exp_m] || obs_len !== p_len[exp_m] || obs_id !== p_id[exp_m])
        $display("FAIL rand%0d_ar: grant %0d addr %0h len %0d want %0d %0h %0d", rnd, obs_g, obs_addr, obs_len, exp_m, p_addr[exp_m], p_len[exp_m]); else passed++;
      bad = 0;
      for (int i = 0; i < rx_data.size(); i++)
        if (rx_data[i] !== tx_data[i] || rx_last[i] !== (i == rx_data.size() - 1)) bad++;
      total++; if (rx_data.size() != int'(p_len[exp_m]) + 1 || bad != 0 || mirror_bad != 0 || route_bad != 0 || busy_after !== 1'b0)
        $display("FAIL rand%0d_r: beats %0d bad %0d mirror %0d route %0d busy %0b want %0d 0 0 0 0",
                 rnd, rx_data.size(), bad, mirror_bad, route_bad, busy_after, int'(p_len[exp_m]) + 1); else passed++;
      model_ptr = (exp_m + 1) % N;
    end
    m_arvalid = '0;
  endtask

  task automatic test_timeout();
    int idx;
    bit seen;
    m_arvalid = '0; rand_payload(0); persist[0] = 1'b0; m_arvalid[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(posedge clk); #2;
      if (s_arvalid) seen = 1'b1;
    end
    s_arready = 1'b1;
    @(posedge clk); #1;
    s_arready = 1'b0; m_arvalid[0] = 1'b0;
    total++; if (!seen) $display("FAIL timeout_ar: s_arvalid never seen want 1"); else passed++;
    idx = -1;
    for (int c = 0; c < 700; c++) begin
      if (c == 200) begin s_rvalid = 1'b1; s_rlast = 1'b0; m_rready[0] = 1'b1; end
      #1;
      if (c != 200 && m_rvalid[0]) begin idx = c; break; end
      @(posedge clk); #1;
      s_rvalid = 1'b0; m_rready = '0;
    end
    // One mid-burst beat at cycle 200 restarts the idle count.
    total++; if (idx != 201 + TO) $display("FAIL timeout_cycle: abort at %0d want %0d", idx, 201 + TO); else passed++;
    total++; if (m_rresp !== RESP_SLVERR || m_rlast !== 1'b1 || m_rdata !== '0 || m_rid !== p_id[0])
      $display("FAIL timeout_resp: resp %0b last %0b data %0h id %0h want 10 1 0 %0h", m_rresp, m_rlast, m_rdata, m_rid, p_id[0]); else passed++;
    total++; if (s_rready !== 1'b1 || m_rvalid !== 2'b01 || busy !== 1'b1)
      $display("FAIL timeout_hs: s_rready %0b m_rvalid %0b busy %0b want 1 01 1", s_rready, m_rvalid, busy); else passed++;
    s_rvalid = 1'b1; s_rdata = $urandom | 32'h1;
    @(posedge clk); #2;
    total++; if (m_rvalid !== 2'b01 || m_rdata !== '0)
      $display("FAIL timeout_drain: m_rvalid %0b data %0h want 01 0", m_rvalid, m_rdata); else passed++;
    m_rready[0] = 1'b1;
    @(posedge clk); #2;
    s_rvalid = 1'b0; m_rready = '0;
    total++; if (busy !== 1'b0) $display("FAIL timeout_idle: busy %0b want 0", busy); else passed++;
    model_ptr = 1;
  endtask

  task automatic test_reset_in_data();
    int exp_m;
    bit seen;
    m_arvalid = '0; rand_payload(0); p_len[0] = 8'd3; persist[0] = 1'b0; m_arvalid[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(posedge clk); #2;
      if (s_arvalid) seen = 1'b1;
    end
    s_arready = 1'b1;
    @(posedge clk); #1;
    s_arready = 1'b0; m_arvalid[0] = 1'b0;
    s_rvalid = 1'b1; s_rlast = 1'b0; s_rdata = $urandom; m_rready[0] = 1'b1;
    @(posedge clk); #1;
    total++; if (!seen || busy !== 1'b1) $display("FAIL rstdata_pre: seen %0b busy %0b want 1 1", seen, busy); else passed++;
    rst = 1'b0; #1;
    total++; if (busy !== 1'b0 || m_rvalid !== '0 || s_rready !== 1'b0 || s_arvalid !== 1'b0 || m_rdata !== '0 || grant !== '0)
      $display("FAIL rstdata_async: busy %0b rvalid %0b rready %0b arvalid %0b data %0h grant %0d want 0",
               busy, m_rvalid, s_rready, s_arvalid, m_rdata, grant); else passed++;
    repeat (2) @(posedge clk);
    #1;
    s_rvalid = 1'b0; m_rready = '0; rst = 1'b1; model_ptr = 0;
    @(posedge clk); #1;
    rand_payload(0); rand_payload(1); persist[0] = 1'b0; persist[1] = 1'b0;
    m_arvalid = 2'b11;
    for (int rnd = 0; rnd < 2; rnd++) begin
      exp_m = exp_pick(m_arvalid, model_ptr);
      serve_txn(int'(p_len[exp_m]), 1'b0, $urandom);
      total++; if (!ar_ok || obs_g !== exp_m || obs_addr !== p_addr[exp_m] || rx_data.size() != int'(p_len[exp_m]) + 1 || busy_after !== 1'b0)
        $display("FAIL rstdata_after%0d: grant %0d addr %0h beats %0d want %0d %0h %0d", rnd, obs_g, obs_addr, rx_data.size(), exp_m, p_addr[exp_m], int'(p_len[exp_m]) + 1); else passed++;
      model_ptr = (exp_m + 1) % N;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin rand_payload(i); persist[i] = 1'b0; end
    rst = 1'b0; m_arvalid = '0; m_rready = '0; s_arready = 1'b0;
    s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0; s_rid = '0; s_rresp = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_fairness();
    test_burst_backpressure();
    test_random();
    test_timeout();
    test_reset_in_data();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
